ram_req_ctrl: RTL and testbench
===============================

// Module: ram_req_ctrl
// PURPOSE
//  Request front-end sitting directly upstream of the single-port synchronous RAM.
//  Accepts valid/ready read/write requests and drives RAM wr_enb/rd_enb/addr/data_in.
//  Tracks read latency and returns read data on a valid/ready response channel, buffered against backpressure.
//  Optionally zero-fills the whole RAM after reset before accepting traffic.
// PARAMETERS
//  ADDR_W       4  RAM address width; RAM depth = 2**ADDR_W
//  DATA_W       8  RAM data width
//  RD_LATENCY   1  RAM cycles from rd_enb to valid data_out (1..3)
//  RSP_DEPTH    4  response FIFO entries (power of 2, >= RD_LATENCY+1)
//  CLEAR_ON_RST 1  1: zero-fill RAM after reset; 0: go straight to RUN
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller accepts request this cycle
//  req_write  in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       read data available
//  rsp_ready  in   1       consumer takes response
//  rsp_rdata  out  DATA_W  read data, in request order
//  wr_enb     out  1       RAM write enable
//  rd_enb     out  1       RAM read enable
//  addr       out  ADDR_W  RAM address
//  data_in    out  DATA_W  RAM write data
//  data_out   in   DATA_W  RAM read data
//  init_done  out  1       high once RAM clear finished (or immediately if CLEAR_ON_RST=0)
// BEHAVIOUR
//  Reset: all outputs 0; FSM->CLEAR (CLEAR_ON_RST=1) else RUN; FIFO, credit and clear counters = 0.
//  Reset mid-operation: drops in-flight reads and buffered responses; clear restarts from addr 0.
//  FSM CLEAR: wr_enb=1, data_in=0, addr=clr_cnt, clr_cnt++ each cycle; req_ready=0.
//   At clr_cnt==2**ADDR_W-1 (written that cycle) -> RUN next cycle; init_done=1 from then until rst.
//  FSM RUN: req_ready = (credits < RSP_DEPTH), credits = in-flight reads + FIFO occupancy.
//   Writes do not consume credit, but share req_ready (in-order, single RAM port).
//  Accept = req_valid & req_ready. Accepted write: wr_enb/addr/data_in registered, RAM sees them next cycle.
//  Accepted read: rd_enb/addr registered; tag shifts through RD_LATENCY-stage valid pipe.
//   data_out captured into FIFO RD_LATENCY cycles after rd_enb.
//  Accept->rsp_valid latency = RD_LATENCY+1 cycles with empty FIFO (registered RAM drive).
//  wr_enb and rd_enb never high together; idle cycles drive both 0, addr/data_in hold last value.
//  Credits: +1 on read accept, -1 on rsp_valid&rsp_ready; both same cycle -> unchanged.
//  FIFO: rsp_valid = !empty; rsp_rdata = head, stable while rsp_valid&!rsp_ready.
//   Credit scheme guarantees no overflow; overflow/underflow = assertion failure.
//  Read after write to same addr, back-to-back: returns newly written data (RAM write-first ordering).
//  Pointer wrap at RSP_DEPTH uses extra MSB for full/empty distinction.
// STRUCTURE
//  Package ram_ctrl_pkg: typedef enum logic [0:0] {CLEAR, RUN} ctrl_state_e; typedefs addr_t/data_t
//   sized from package constants; req/rsp packed structs.
//  Sub-module ram_rsp_fifo (synchronous FIFO, DEPTH/WIDTH params, push/pop/full/empty/count).
//  Top: FSM + clear counter, credit counter, RAM drive registers, read-valid shift pipe.
// TESTING
//  1 rst 1 cycle, CLEAR_ON_RST=1 -> 16 wr_enb cycles, addr 0..15, data_in 0; init_done at cycle 17; req_ready 0 during.
//  2 write 0xA5@3, then read @3, rsp_ready=1 -> rsp_rdata=0xA5, rsp_valid 2 cycles after read accept.
//  3 rsp_ready=0, issue 6 reads -> exactly 4 accepted, req_ready=0 after; release -> 4 rsps in order, no loss.
//  4 reads @1,@2,@3 back-to-back after writes 0x11,0x22,0x33 -> rsp order 0x11,0x22,0x33.
//  5 read accepted then rst next cycle -> no rsp_valid after reset, CLEAR restarts at addr 0.
//  6 RD_LATENCY=3, reads every cycle with rsp_ready=1 -> sustained 1 rsp/cycle, latency 4.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared types and constants for the RAM request front-end.
//   PKG_*          default sizing for ram_req_ctrl parameters
//   ctrl_state_e   controller state: CLEAR (zero-fill after reset) or RUN
//   addr_t/data_t  address / data words at the default sizing
//   req_t/rsp_t    request / response payloads at the default sizing
//   credit_width() bits needed to count 0..depth response credits
// -----------------------------------------------------------------------------
package ram_ctrl_pkg;

    localparam int PKG_ADDR_W     = 4;
    localparam int PKG_DATA_W     = 8;
    localparam int PKG_RD_LATENCY = 1;
    localparam int PKG_RSP_DEPTH  = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_e;

    typedef logic [PKG_ADDR_W-1:0] addr_t;
    typedef logic [PKG_DATA_W-1:0] data_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
    } req_t;

    typedef struct packed {
        data_t rdata;
    } rsp_t;

    // The counter must hold the value 'depth' itself, hence depth+1 states.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// ram_rsp_fifo
// Synchronous FIFO buffering read responses against consumer backpressure.
// Head entry is presented combinationally so it is valid together with !empty.
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write an entry
//   pop,  pop_data  remove head entry / head entry contents
//   full, empty     status flags
//   count           current occupancy (0..DEPTH)
// DEPTH must be a power of two; pointers carry one extra MSB so that
// full (MSBs differ, rest equal) and empty (all equal) are distinguishable.
// -----------------------------------------------------------------------------
module ram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count    = wptr_q - rptr_q;
    assign pop_data = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            // Upstream credit accounting must make these impossible.
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

    // Storage has no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// ram_req_ctrl
// Request front-end for a single-port synchronous RAM.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_write selects write/read,
//   req_addr, req_wdata      request address and write data
//   rsp_valid/rsp_ready      read-response handshake, rsp_rdata in request order
//   wr_enb, rd_enb, addr,    registered RAM drive
//   data_in
//   data_out                 RAM read data, valid RD_LATENCY cycles after rd_enb
//   init_done                high once the post-reset zero-fill has finished
// After reset the RAM is optionally zero-filled (CLEAR) before requests are
// taken (RUN). Reads are admitted only while a response slot is guaranteed:
// credits count reads in flight plus responses buffered, capped at RSP_DEPTH.
// -----------------------------------------------------------------------------
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W       = PKG_ADDR_W,
    parameter int DATA_W       = PKG_DATA_W,
    parameter int RD_LATENCY   = PKG_RD_LATENCY,
    parameter int RSP_DEPTH    = PKG_RSP_DEPTH,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_enb,
    output logic              rd_enb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              init_done
);

    localparam int             CW          = credit_width(RSP_DEPTH);
    localparam logic [CW-1:0]  CREDIT_MAX  = CW'(RSP_DEPTH);
    localparam ctrl_state_e    RESET_STATE = CLEAR_ON_RST ? CLEAR : RUN;

    ctrl_state_e             state_q,     state_d;
    logic [ADDR_W-1:0]       clr_cnt_q,   clr_cnt_d;
    logic [CW-1:0]           credit_q,    credit_d;
    logic                    wr_enb_q,    wr_enb_d;
    logic                    rd_enb_q,    rd_enb_d;
    logic [ADDR_W-1:0]       addr_q,      addr_d;
    logic [DATA_W-1:0]       data_in_q,   data_in_d;
    logic                    init_done_q, init_done_d;
    logic [RD_LATENCY-1:0]   vld_pipe_q,  vld_pipe_d;

    logic                    req_acc;
    logic                    rd_acc;
    logic                    rsp_pop;
    logic                    rsp_push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_rdata;
    logic [$clog2(RSP_DEPTH):0] fifo_count;

    // Requests wait for the zero-fill to complete (init_done follows RUN by
    // one cycle), and reads need a free credit. Writes share the same ready
    // so that traffic stays in order on the single RAM port.
    assign req_ready = (state_q == RUN) && init_done_q && (credit_q < CREDIT_MAX);
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && !req_write;
    assign rsp_valid = !fifo_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Read-valid pipe: stage 0 marks the cycle the RAM samples rd_enb, the
    // last stage marks the cycle data_out holds that read's data.
    assign rsp_push      = vld_pipe_q[RD_LATENCY-1];
    assign vld_pipe_d[0] = rd_enb_q;

    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_vld_pipe
            assign vld_pipe_d[gi] = vld_pipe_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_enb_d    = 1'b0;
        rd_enb_d    = 1'b0;
        addr_d      = addr_q;       // address and data hold when idle
        data_in_d   = data_in_q;
        init_done_d = init_done_q;

        unique case (state_q)
            CLEAR: begin
                wr_enb_d  = 1'b1;
                data_in_d = '0;
                addr_d    = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                if (req_acc) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        wr_enb_d  = 1'b1;
                        data_in_d = req_wdata;
                    end else begin
                        rd_enb_d  = 1'b1;
                    end
                end
            end
            default: state_d = RESET_STATE;
        endcase

        // A read admitted and a response retired in the same cycle cancel out.
        credit_d = credit_q;
        if (rd_acc && !rsp_pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!rd_acc && rsp_pop) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            credit_q    <= '0;
            wr_enb_q    <= 1'b0;
            rd_enb_q    <= 1'b0;
            addr_q      <= '0;
            data_in_q   <= '0;
            init_done_q <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            credit_q    <= credit_d;
            wr_enb_q    <= wr_enb_d;
            rd_enb_q    <= rd_enb_d;
            addr_q      <= addr_d;
            data_in_q   <= data_in_d;
            init_done_q <= init_done_d;
            vld_pipe_q  <= vld_pipe_d;
            assert (!(wr_enb_q && rd_enb_q));
            assert (credit_q <= CREDIT_MAX);
            assert (CW'(fifo_count) <= credit_q);
            assert (!(rsp_push && fifo_full && !rsp_pop));
        end
    end

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (data_out),
        .pop       (rsp_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr_enb    = wr_enb_q;
    assign rd_enb    = rd_enb_q;
    assign addr      = addr_q;
    assign data_in   = data_in_q;
    assign init_done = init_done_q;
    assign rsp_rdata = fifo_rdata;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_req_ctrl
// Two controllers share one clock: dut (RD_LATENCY=1, RSP_DEPTH=4) and dut3
// (RD_LATENCY=3, RSP_DEPTH=8), each driving its own behavioural RAM.
// Stimulus pushes expected read responses into a queue per controller; a
// monitor per controller pops and compares whenever a response handshake
// occurs, including the exact arrival cycle where one is expected.
// -----------------------------------------------------------------------------
module tb_ram_req_ctrl;

    typedef struct {
        logic [7:0] data;
        int         due;    // arrival cycle, or -1 when not timed
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pop   = 0;

    exp_t       exp_q[$];
    exp_t       exp3_q[$];

    // dut signals
    logic       rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [3:0] req_addr, addr;
    logic [7:0] req_wdata, rsp_rdata, data_in, data_out;
    logic       wr_enb, rd_enb, init_done;

    // dut3 signals
    logic       rst3, req_valid3, req_ready3, req_write3, rsp_valid3, rsp_ready3;
    logic [3:0] req_addr3, addr3;
    logic [7:0] req_wdata3, rsp_rdata3, data_in3, data_out3;
    logic       wr_enb3, rd_enb3, init_done3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_req_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LATENCY(1), .RSP_DEPTH(4), .CLEAR_ON_RST(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .wr_enb(wr_enb), .rd_enb(rd_enb), .addr(addr), .data_in(data_in),
        .data_out(data_out), .init_done(init_done)
    );

    ram_req_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LATENCY(3), .RSP_DEPTH(8), .CLEAR_ON_RST(1'b1)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write3), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
        .wr_enb(wr_enb3), .rd_enb(rd_enb3), .addr(addr3), .data_in(data_in3),
        .data_out(data_out3), .init_done(init_done3)
    );

    // Behavioural RAMs: one-cycle read, and three-stage read pipeline.
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] p3   [3];

    always @(posedge clk) begin
        if (wr_enb) mem1[addr] <= data_in;
        if (rd_enb) data_out <= mem1[addr];
    end

    always @(posedge clk) begin
        if (wr_enb3) mem3[addr3] <= data_in3;
        if (rd_enb3) p3[0] <= mem3[addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign data_out3 = p3[2];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok %s = 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Response monitors
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h, expected no response (cycle %0d)", rsp_rdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_pop++;
                check("rsp_rdata", rsp_rdata, e.data);
                if (e.due >= 0) check("rsp_latency_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3 && rsp_valid3 && rsp_ready3) begin
            if (exp3_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp3: got rdata 0x%0h, expected no response (cycle %0d)", rsp_rdata3, cyc);
            end else begin
                exp_t e;
                e = exp3_q.pop_front();
                check("rsp3_rdata", rsp_rdata3, e.data);
                if (e.due >= 0) check("rsp3_latency_cycle", cyc, e.due);
            end
        end
    end

    // Present one request, hold it until accepted; returns just after the
    // accepting edge. For reads, d is the expected data.
    task automatic issue(input int which, input logic w, input logic [3:0] a,
                         input logic [7:0] d, input bit timed, output int acc);
        int   n;
        logic ok;
        exp_t e;
        n  = 0;
        ok = 1'b0;
        if (which == 0) begin
            req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        end else begin
            req_valid3 = 1'b1; req_write3 = w; req_addr3 = a; req_wdata3 = d;
        end
        while (!ok && n < 100) begin
            @(negedge clk);
            if ((which == 0) ? req_ready : req_ready3) ok = 1'b1;
            else n++;
        end
        if (!ok) check("req_accept_timeout", 0, 1);
        acc = cyc + 1;
        if (ok && !w) begin
            e.data = d;
            e.due  = timed ? acc + ((which == 0) ? 2 : 4) : -1;
            if (which == 0) exp_q.push_back(e);
            else            exp3_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (which == 0) req_valid = 1'b0;
        else            req_valid3 = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? exp_q.size() : exp3_q.size()) > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", (which == 0) ? exp_q.size() : exp3_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc, prev, nacc, a, nv, n, pops0;
        logic [3:0] i4;
        logic [7:0] t3_data [6];
        t3_data = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        rst3 = 1'b1; req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b1;

        // 1: reset state, then 16 zero-fill writes, then init_done
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {wr_enb, rd_enb, rsp_valid, init_done, req_ready, addr, data_in}, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i4 = 4'(i);
            check("clear_cycle", {wr_enb, addr, data_in, req_ready, init_done},
                  {1'b1, i4, 8'h00, 1'b0, 1'b0});
        end
        @(negedge clk);
        check("init_done_after_clear", {init_done, wr_enb, req_ready}, 3'b101);
        @(posedge clk);
        #1;

        // 2: write then read same address, timed response
        issue(0, 1'b1, 4'd3, 8'hA5, 1'b0, acc);
        issue(0, 1'b0, 4'd3, 8'hA5, 1'b1, acc);
        drain(0);

        // 4: three writes then three back-to-back reads
        issue(0, 1'b1, 4'd1, 8'h11, 1'b0, acc);
        issue(0, 1'b1, 4'd2, 8'h22, 1'b0, acc);
        issue(0, 1'b1, 4'd3, 8'h33, 1'b0, acc);
        issue(0, 1'b0, 4'd1, 8'h11, 1'b1, acc);
        issue(0, 1'b0, 4'd2, 8'h22, 1'b1, acc);
        issue(0, 1'b0, 4'd3, 8'h33, 1'b1, acc);
        drain(0);

        // 3: backpressure, six reads offered, only four admitted
        rsp_ready = 1'b0;
        nacc = 0;
        a = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready && a < 6) begin
                exp_q.push_back('{t3_data[a], -1});
                nacc++;
                a++;
            end
            @(posedge clk);
            #1;
            if (a < 6) req_addr = 4'(a);
        end
        req_valid = 1'b0;
        check("bp_reads_accepted", nacc, 4);
        @(negedge clk);
        check("bp_req_ready_low", {req_ready, rsp_valid}, 2'b01);
        check("bp_head_stable", rsp_rdata, 8'h00);
        pops0 = n_pop;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain(0);
        check("bp_rsp_count", n_pop - pops0, 4);

        // 5: reset with a read in flight
        issue(0, 1'b0, 4'd3, 8'h33, 1'b1, acc);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {wr_enb, rd_enb, rsp_valid, init_done}, 0);
        @(negedge clk);
        check("clear_restart_addr0", {wr_enb, addr, data_in}, {1'b1, 4'd0, 8'h00});
        nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        check("no_rsp_after_rst", nv, 0);
        check("init_done_after_reclear", init_done, 1);

        // 6: RD_LATENCY=3 controller, a read every cycle
        @(posedge clk);
        #1 rst3 = 1'b0;
        n = 0;
        while (!init_done3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("dut3_init_done", init_done3, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b1, 4'(i), 8'(8'h40 + i), 1'b0, acc);
        end
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1, 1'b0, 4'(i), 8'(8'h40 + i), 1'b1, acc);
            if (i > 0) check("dut3_read_every_cycle", acc, prev + 1);
            prev = acc;
        end
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
